// File: rtl/uart_frame_transmitter_pkg.sv
// Shared types and helpers for the UART frame transmitter.
// TX_BREAK_EN adds the BREAK state to the state encoding.
package uart_pkg;

`ifdef TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE,
        READ_ENABLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE,
        READ_ENABLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;
`endif

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    localparam int unsigned DIV_MAX = 65535;

    // Clocks per bit when the runtime divisor is left at zero.
    function automatic int unsigned default_div(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        if (baud == 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

    // Bits needed to count from 0 up to v-1.
    function automatic int unsigned clog2_w(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_frame_transmitter_if.sv
// FIFO-side and line-side signals of the UART frame transmitter.
// brk exists only when TX_BREAK_EN is defined.
interface uart_frame_transmitter_if #(
    parameter logic [31:0] WORD_WIDTH = 32'd8
);
    logic [WORD_WIDTH-1:0] din;
    logic                  empty;
    logic                  re;
    logic [1:0]            parity_mode;
    logic                  two_stop;
    logic [15:0]           divisor;
    logic                  busy;
    logic                  dout;
`ifdef TX_BREAK_EN
    logic                  brk;
`endif

    modport master (
`ifdef TX_BREAK_EN
        input  brk,
`endif
        input  din,
        input  empty,
        input  parity_mode,
        input  two_stop,
        input  divisor,
        output re,
        output busy,
        output dout
    );

    modport slave (
`ifdef TX_BREAK_EN
        output brk,
`endif
        output din,
        output empty,
        output parity_mode,
        output two_stop,
        output divisor,
        input  re,
        input  busy,
        input  dout
    );

endinterface

// File: rtl/uart_frame_transmitter_baud_counter.sv
// Bit-time counter: ticks bit_done on the last cycle of each bit.
// Held at zero while clr is high so every bit starts from a clean count.
module uart_baud_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] div,
    output logic        bit_done
);

    logic [15:0] cnt;

    assign bit_done = !clr && (cnt == div - 16'd1);

    // Count up to div-1, then wrap for the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_frame_transmitter.sv
// UART serialiser draining a standard FIFO onto the TX pin.
// Define TX_BREAK_EN to add line-break generation via brk.
module uart_frame_transmitter
    import uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd230400,
    parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_frame_transmitter_if.master bus
);

    localparam int unsigned DEF_DIV =
        default_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int IDX_W = clog2_w(WORD_WIDTH + 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 32'd1);

    if (WORD_WIDTH < 32'd5 || WORD_WIDTH > 32'd9) begin : g_bad_width
        $error("WORD_WIDTH must be within 5..9");
    end

    if (DEF_DIV < 1 || DEF_DIV > DIV_MAX) begin : g_bad_div
        $error("CLOCK_FREQUENCY/BAUD_RATE must be within 1..65535");
    end

    state_e                state;
    logic [WORD_WIDTH-1:0] sr;
    logic [IDX_W-1:0]      idx;
    logic                  par_bit;
    logic                  par_en;
    logic                  two_q;
    logic [15:0]           div_q;
    logic                  re_q;
    logic                  busy_q;
    logic                  dout_q;
    logic                  cnt_clr;
    logic                  bit_done;
    logic [15:0]           eff_div;
`ifdef TX_BREAK_EN
    logic                  brk_tail;
`endif

    assign eff_div = (bus.divisor == 16'd0) ? 16'(DEF_DIV) : bus.divisor;

    assign bus.re   = re_q;
    assign bus.busy = busy_q;
    assign bus.dout = dout_q;

    // Bit timer runs only in states that hold the line for bit times.
    always_comb begin
        cnt_clr = 1'b1;
        unique case (state)
            START, DATA, PARITY, STOP: cnt_clr = 1'b0;
`ifdef TX_BREAK_EN
            BREAK:                     cnt_clr = !brk_tail;
`endif
            default:                   cnt_clr = 1'b1;
        endcase
    end

    uart_baud_counter u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .div      (div_q),
        .bit_done (bit_done)
    );

    // Frame sequencer with registered re/busy/dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            idx      <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            two_q    <= 1'b0;
            div_q    <= '0;
            re_q     <= 1'b0;
            busy_q   <= 1'b0;
            dout_q   <= 1'b1;
`ifdef TX_BREAK_EN
            brk_tail <= 1'b0;
`endif
        end else begin
            re_q <= 1'b0;
            unique case (state)
                IDLE: begin
`ifdef TX_BREAK_EN
                    if (bus.brk) begin
                        state    <= BREAK;
                        busy_q   <= 1'b1;
                        dout_q   <= 1'b0;
                        brk_tail <= 1'b0;
                        div_q    <= eff_div;
                        idx      <= '0;
                    end else
`endif
                    if (!bus.empty) begin
                        state  <= READ_ENABLE;
                        re_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                READ_ENABLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    sr      <= bus.din;
                    par_bit <= (bus.parity_mode == PAR_ODD) ?
                               ~^bus.din : ^bus.din;
                    par_en  <= (bus.parity_mode == PAR_EVEN) ||
                               (bus.parity_mode == PAR_ODD);
                    two_q   <= bus.two_stop;
                    div_q   <= eff_div;
                    dout_q  <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_done) begin
                        state  <= DATA;
                        dout_q <= sr[0];
                        idx    <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (par_en) begin
                                state  <= PARITY;
                                dout_q <= par_bit;
                            end else begin
                                state  <= STOP;
                                dout_q <= 1'b1;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            sr     <= sr >> 1;
                            dout_q <= sr[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        dout_q <= 1'b1;
                        idx    <= '0;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (two_q && idx == '0) begin
                            idx <= idx + 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            idx    <= '0;
                        end
                    end
                end
`ifdef TX_BREAK_EN
                BREAK: begin
                    if (!brk_tail) begin
                        if (!bus.brk) begin
                            brk_tail <= 1'b1;
                            dout_q   <= 1'b1;
                        end
                    end else if (bit_done) begin
                        if (idx == '0) begin
                            idx <= idx + 1'b1;
                        end else begin
                            state    <= IDLE;
                            busy_q   <= 1'b0;
                            brk_tail <= 1'b0;
                            idx      <= '0;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
